fpu_exec_tracker: RTL and testbench

FPU_EXEC_TRACKER -- requirements
Module: fpu_exec_tracker

---
 rtl/is_pkg.sv | 31 +++
 rtl/fpu_wb_reservation.sv | 67 ++++++
 rtl/fpu_exec_tracker.sv | 152 +++++++++++++++
 tb/tb_fpu_exec_tracker.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/is_pkg.sv
// is_pkg -- shared types and default sizing for the FP execution tracker.
//   fp_op_e   : 2-bit FP opcode carried on insn_op_in
//   wb_slot_t : one writeback reservation slot {valid, is_mul, dest, ptr}
//   DEF_*     : default latencies and widths used as parameter defaults
package is_pkg;

    localparam int unsigned DEF_FP_ADD_LATENCY  = 1;
    localparam int unsigned DEF_FP_MULT_LATENCY = 13;
    localparam int unsigned DEF_MAX_INFLIGHT    = 8;
    localparam int unsigned DEF_WORD_SIZE       = 64;

    localparam int unsigned NUM_PHYS_REGS       = 64;
    localparam int unsigned ROB_DEPTH           = 32;
    localparam int unsigned DEF_PHYS_REG_W      = $clog2(NUM_PHYS_REGS);
    localparam int unsigned DEF_ROB_PTR_W       = $clog2(ROB_DEPTH);

    typedef enum logic [1:0] {
        FADD = 2'd0,
        FSUB = 2'd1,
        FMUL = 2'd2,
        NONE = 2'd3
    } fp_op_e;

    typedef struct packed {
        logic                      valid;
        logic                      is_mul;
        logic [DEF_PHYS_REG_W-1:0] dest;
        logic [DEF_ROB_PTR_W-1:0]  ptr;
    } wb_slot_t;

endpackage

// File: rtl/fpu_wb_reservation.sv
// fpu_wb_reservation -- writeback reservation line.
// A DEPTH-entry shift line; slot 0 holds the entry whose result is due this
// cycle. Every clock the line shifts toward slot 0 and an optional new entry
// is written at ins_idx_in (post-shift position).
//   clk_in, rst_N_in : clock, asynchronous active-low reset
//   clear_in         : synchronous clear of every slot
//   ins_en_in        : write ins_slot_in at index ins_idx_in this clock
//   probe_off_in     : offset queried for a free slot (>= DEPTH reads as free)
//   probe_free_out   : slot at probe_off_in is empty
//   slot0_out        : current head-of-line entry
module fpu_wb_reservation
    import is_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_FP_MULT_LATENCY,
    parameter int unsigned OFF_W = $clog2(DEF_FP_MULT_LATENCY + 1)
) (
    input  logic             clk_in,
    input  logic             rst_N_in,
    input  logic             clear_in,
    input  logic             ins_en_in,
    input  logic [OFF_W-1:0] ins_idx_in,
    input  wb_slot_t         ins_slot_in,
    input  logic [OFF_W-1:0] probe_off_in,
    output logic             probe_free_out,
    output wb_slot_t         slot0_out
);

    wb_slot_t slots [DEPTH];

    always_ff @(posedge clk_in or negedge rst_N_in) begin
        if (!rst_N_in) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                slots[i] <= '0;
            end
        end else if (clear_in) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                slots[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
                slots[i] <= slots[i+1];
            end
            slots[DEPTH-1] <= '0;
            // Insert overrides the shifted value; the free-slot probe
            // guarantees the overridden value was empty.
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (ins_en_in && (ins_idx_in == OFF_W'(i))) begin
                    slots[i] <= ins_slot_in;
                end
            end
        end
    end

    // Probing offset L looks at slot L before the shift, i.e. the slot that
    // will become L-1 next cycle and reach slot 0 exactly L cycles later.
    always_comb begin
        probe_free_out = 1'b1;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (probe_off_in == OFF_W'(i)) begin
                probe_free_out = !slots[i].valid;
            end
        end
    end

    assign slot0_out = slots[0];

endmodule

// File: rtl/fpu_exec_tracker.sv
// fpu_exec_tracker -- issues FP add/sub/mul ops to fixed-latency units and
// writes results back, guaranteeing one writeback per cycle by reserving the
// writeback cycle at issue time.
//   clk_in, rst_N_in             : clock, asynchronous active-low reset
//   flush_in                     : synchronous squash of all in-flight ops
//   insn_*_in                    : offered op (valid, opcode, operands, dest, ROB ptr)
//   ready_out                    : offered op can be accepted this cycle
//   fpu_a_out/fpu_b_out          : operands to the FP units (0 when not issuing)
//   fpadd_valid_out/fpmult_valid_out : issue strobes
//   fp{add,mult}_result_in/_valid_in : unit results
//   wb_*_out                     : regfile write + ROB done
//   inflight_count_out           : outstanding ops
//   error_out                    : sticky: an expected result never arrived
module fpu_exec_tracker
    import is_pkg::*;
#(
    parameter int unsigned FP_ADD_LATENCY  = DEF_FP_ADD_LATENCY,
    parameter int unsigned FP_MULT_LATENCY = DEF_FP_MULT_LATENCY,
    parameter int unsigned MAX_INFLIGHT    = DEF_MAX_INFLIGHT,
    parameter int unsigned WORD_SIZE       = DEF_WORD_SIZE,
    parameter int unsigned PHYS_REG_W      = DEF_PHYS_REG_W,
    parameter int unsigned ROB_PTR_W       = DEF_ROB_PTR_W
) (
    input  logic                          clk_in,
    input  logic                          rst_N_in,
    input  logic                          flush_in,
    input  logic                          insn_valid_in,
    input  logic [1:0]                    insn_op_in,
    input  logic [WORD_SIZE-1:0]          insn_r1_in,
    input  logic [WORD_SIZE-1:0]          insn_r2_in,
    input  logic [PHYS_REG_W-1:0]         insn_dest_in,
    input  logic [ROB_PTR_W-1:0]          insn_ptr_in,
    output logic                          ready_out,
    output logic [WORD_SIZE-1:0]          fpu_a_out,
    output logic [WORD_SIZE-1:0]          fpu_b_out,
    output logic                          fpadd_valid_out,
    output logic                          fpmult_valid_out,
    input  logic [WORD_SIZE-1:0]          fpadd_result_in,
    input  logic [WORD_SIZE-1:0]          fpmult_result_in,
    input  logic                          fpadd_valid_in,
    input  logic                          fpmult_valid_in,
    output logic                          wb_en_out,
    output logic [PHYS_REG_W-1:0]         wb_index_out,
    output logic [WORD_SIZE-1:0]          wb_data_out,
    output logic [ROB_PTR_W-1:0]          wb_ptr_out,
    output logic [$clog2(MAX_INFLIGHT):0] inflight_count_out,
    output logic                          error_out
);

    localparam int unsigned CNT_W = $clog2(MAX_INFLIGHT) + 1;
    localparam int unsigned OFF_W = $clog2(FP_MULT_LATENCY + 1);

    fp_op_e           op;
    logic             is_mul_op;
    logic [OFF_W-1:0] lat;
    logic             probe_free;
    logic             accept;
    wb_slot_t         ins_slot;
    wb_slot_t         slot0;
    logic             unit_valid;
    logic             retire;
    logic             drop;
    logic [CNT_W-1:0] count_q;
    logic             error_q;

    assign op = fp_op_e'(insn_op_in);

    // ---------------- issue decode ----------------
    always_comb begin
        is_mul_op = (op == FMUL);
        lat       = is_mul_op ? OFF_W'(FP_MULT_LATENCY) : OFF_W'(FP_ADD_LATENCY);
    end

    assign ready_out = rst_N_in && !flush_in
                       && (count_q < CNT_W'(MAX_INFLIGHT)) && probe_free;
    assign accept    = insn_valid_in && (op != NONE) && ready_out;

    always_comb begin
        ins_slot        = '0;
        ins_slot.valid  = 1'b1;
        ins_slot.is_mul = is_mul_op;
        ins_slot.dest   = DEF_PHYS_REG_W'(insn_dest_in);
        ins_slot.ptr    = DEF_ROB_PTR_W'(insn_ptr_in);
    end

    always_comb begin
        fpu_a_out        = '0;
        fpu_b_out        = '0;
        fpadd_valid_out  = 1'b0;
        fpmult_valid_out = 1'b0;
        if (accept) begin
            fpu_a_out = insn_r1_in;
            fpu_b_out = insn_r2_in;
            // Subtraction is an add with the second operand's sign flipped.
            if (op == FSUB) begin
                fpu_b_out[WORD_SIZE-1] = ~insn_r2_in[WORD_SIZE-1];
            end
            fpadd_valid_out  = !is_mul_op;
            fpmult_valid_out = is_mul_op;
        end
    end

    // ---------------- reservation line ----------------
    fpu_wb_reservation #(
        .DEPTH (FP_MULT_LATENCY),
        .OFF_W (OFF_W)
    ) u_resv (
        .clk_in         (clk_in),
        .rst_N_in       (rst_N_in),
        .clear_in       (flush_in),
        .ins_en_in      (accept),
        .ins_idx_in     (lat - OFF_W'(1)),
        .ins_slot_in    (ins_slot),
        .probe_off_in   (lat),
        .probe_free_out (probe_free),
        .slot0_out      (slot0)
    );

    // ---------------- writeback ----------------
    always_comb begin
        unit_valid   = slot0.is_mul ? fpmult_valid_in : fpadd_valid_in;
        retire       = slot0.valid && !flush_in;
        drop         = retire && !unit_valid;
        wb_en_out    = retire && unit_valid;
        wb_index_out = '0;
        wb_ptr_out   = '0;
        wb_data_out  = '0;
        if (wb_en_out) begin
            wb_index_out = PHYS_REG_W'(slot0.dest);
            wb_ptr_out   = ROB_PTR_W'(slot0.ptr);
            wb_data_out  = slot0.is_mul ? fpmult_result_in : fpadd_result_in;
        end
    end

    always_ff @(posedge clk_in or negedge rst_N_in) begin
        if (!rst_N_in) begin
            count_q <= '0;
            error_q <= 1'b0;
        end else begin
            if (flush_in) begin
                count_q <= '0;
            end else begin
                count_q <= count_q + CNT_W'(accept) - CNT_W'(retire);
            end
            error_q <= error_q | drop;
        end
    end

    assign inflight_count_out = count_q;
    assign error_out          = error_q;

endmodule

// File: tb/tb_fpu_exec_tracker.sv
module tb_fpu_exec_tracker;
    import is_pkg::*;

    localparam int ADD_L   = 1;
    localparam int MUL_L   = 13;
    localparam int MAX_INF = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT 1 (defaults) ----------------
    logic        rst_n, flush, ivalid;
    logic [1:0]  iop;
    logic [63:0] r1, r2;
    logic [5:0]  idest;
    logic [4:0]  iptr;
    logic        ready;
    logic [63:0] fa, fb;
    logic        addv_o, mulv_o;
    logic [63:0] add_res, mul_res;
    logic        add_v, mul_v;
    logic        wb_en;
    logic [5:0]  wb_idx;
    logic [63:0] wb_data;
    logic [4:0]  wb_ptr;
    logic [3:0]  cnt;
    logic        err;

    fpu_exec_tracker dut (
        .clk_in(clk), .rst_N_in(rst_n), .flush_in(flush),
        .insn_valid_in(ivalid), .insn_op_in(iop),
        .insn_r1_in(r1), .insn_r2_in(r2), .insn_dest_in(idest), .insn_ptr_in(iptr),
        .ready_out(ready), .fpu_a_out(fa), .fpu_b_out(fb),
        .fpadd_valid_out(addv_o), .fpmult_valid_out(mulv_o),
        .fpadd_result_in(add_res), .fpmult_result_in(mul_res),
        .fpadd_valid_in(add_v), .fpmult_valid_in(mul_v),
        .wb_en_out(wb_en), .wb_index_out(wb_idx), .wb_data_out(wb_data), .wb_ptr_out(wb_ptr),
        .inflight_count_out(cnt), .error_out(err)
    );

    // ---------------- DUT 2 (MAX_INFLIGHT=2) ----------------
    logic        d2_valid, d2_mul_v;
    logic [1:0]  d2_op;
    logic        d2_ready, d2_addv_o, d2_mulv_o, d2_wb_en, d2_err;
    logic [63:0] d2_fa, d2_fb, d2_wb_data;
    logic [5:0]  d2_wb_idx;
    logic [4:0]  d2_wb_ptr;
    logic [1:0]  d2_cnt;

    fpu_exec_tracker #(.MAX_INFLIGHT(2)) dut2 (
        .clk_in(clk), .rst_N_in(rst_n), .flush_in(1'b0),
        .insn_valid_in(d2_valid), .insn_op_in(d2_op),
        .insn_r1_in(64'h0), .insn_r2_in(64'h0), .insn_dest_in(6'd1), .insn_ptr_in(5'd1),
        .ready_out(d2_ready), .fpu_a_out(d2_fa), .fpu_b_out(d2_fb),
        .fpadd_valid_out(d2_addv_o), .fpmult_valid_out(d2_mulv_o),
        .fpadd_result_in(64'h0), .fpmult_result_in(64'h5),
        .fpadd_valid_in(1'b0), .fpmult_valid_in(d2_mul_v),
        .wb_en_out(d2_wb_en), .wb_index_out(d2_wb_idx), .wb_data_out(d2_wb_data), .wb_ptr_out(d2_wb_ptr),
        .inflight_count_out(d2_cnt), .error_out(d2_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: outstanding ops by due cycle ----------------
    typedef struct {
        int         due;
        bit         is_mul;
        logic [5:0] dest;
        logic [4:0] ptr;
    } pend_t;

    pend_t pq[$];
    int    now   = 0;
    bit    m_err = 0;
    bit    e_acc, e_drop;
    int    e_L, s0_idx;

    function automatic int find_due(input int t);
        foreach (pq[i]) if (pq[i].due == t) return i;
        return -1;
    endfunction

    task automatic sample();
        bit          hit, e_ready, match, e_wb;
        logic [63:0] e_a, e_b;
        @(negedge clk);
        e_L     = (iop == FMUL) ? MUL_L : ADD_L;
        hit     = find_due(now + e_L) >= 0;
        e_ready = !flush && (pq.size() < MAX_INF) && !hit;
        if (iop != NONE) chk("ready", ready, e_ready);
        e_acc = ivalid && (iop != NONE) && e_ready;
        e_a   = e_acc ? r1 : 64'h0;
        e_b   = e_acc ? ((iop == FSUB) ? (r2 ^ 64'h8000_0000_0000_0000) : r2) : 64'h0;
        chk("fpu_a", fa, e_a);
        chk("fpu_b", fb, e_b);
        chk("add_strobe", addv_o, e_acc && iop != FMUL);
        chk("mul_strobe", mulv_o, e_acc && iop == FMUL);
        s0_idx = find_due(now);
        match  = 1'b0;
        if (s0_idx >= 0) match = pq[s0_idx].is_mul ? mul_v : add_v;
        e_wb   = (s0_idx >= 0) && !flush && match;
        e_drop = (s0_idx >= 0) && !flush && !match;
        chk("wb_en", wb_en, e_wb);
        if (e_wb) begin
            chk("wb_index", wb_idx, pq[s0_idx].dest);
            chk("wb_ptr", wb_ptr, pq[s0_idx].ptr);
            chk("wb_data", wb_data, pq[s0_idx].is_mul ? mul_res : add_res);
        end
        chk("count", cnt, pq.size());
        chk("error", err, m_err);
    endtask

    task automatic advance();
        pend_t p;
        @(posedge clk);
        if (flush) begin
            pq.delete();
        end else begin
            if (s0_idx >= 0) pq.delete(s0_idx);
            if (e_drop) m_err = 1'b1;
            if (e_acc) begin
                p.due = now + e_L; p.is_mul = (iop == FMUL); p.dest = idest; p.ptr = iptr;
                pq.push_back(p);
            end
        end
        now++;
        #1;
    endtask

    task automatic clr_in();
        ivalid = 0; iop = NONE; r1 = '0; r2 = '0; idest = '0; iptr = '0;
        flush = 0; add_v = 0; mul_v = 0; add_res = '0; mul_res = '0;
    endtask

    // Drive unit results for whatever the model says is due now.
    task automatic set_results(input int resp_pct, input int spur_pct);
        int s;
        add_res = {$urandom, $urandom};
        mul_res = {$urandom, $urandom};
        add_v = 0; mul_v = 0;
        s = find_due(now);
        if (s >= 0 && ($urandom % 100) < resp_pct) begin
            if (pq[s].is_mul) mul_v = 1; else add_v = 1;
        end
        if (($urandom % 100) < spur_pct) begin
            if (s < 0 || pq[s].is_mul) add_v = 1;
            if (s < 0 || !pq[s].is_mul) mul_v = 1;
        end
    endtask

    task automatic idle(input int n, input int resp);
        repeat (n) begin
            clr_in(); set_results(resp, 0); sample(); advance();
        end
    endtask

    task automatic do_reset();
        rst_n = 0;
        pq.delete(); m_err = 0;
        repeat (2) begin
            ivalid = 1; iop = FADD; add_v = 1; mul_v = 1;
            @(negedge clk);
            chk("rst_count", cnt, 0);
            chk("rst_wb_en", wb_en, 0);
            chk("rst_add_strobe", addv_o, 0);
            chk("rst_mul_strobe", mulv_o, 0);
            chk("rst_error", err, 0);
            @(posedge clk); now++; #1;
        end
        rst_n = 1; clr_in();
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [63:0] a, b, exp_a, exp_b;
        bit          exp_add, exp_mul;
    } vec_t;

    vec_t tbl[5];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{FADD, 64'h1111_2222_3333_4444, 64'h8000_0000_0000_0001,
                   64'h1111_2222_3333_4444, 64'h8000_0000_0000_0001, 1, 0};
        tbl[1] = '{FSUB, 64'h3FF0_0000_0000_0000, 64'h4000_0000_0000_0000,
                   64'h3FF0_0000_0000_0000, 64'hC000_0000_0000_0000, 1, 0};
        tbl[2] = '{FSUB, 64'h0000_0000_0000_0007, 64'hC000_0000_0000_1234,
                   64'h0000_0000_0000_0007, 64'h4000_0000_0000_1234, 1, 0};
        tbl[3] = '{FMUL, 64'hAAAA_5555_AAAA_5555, 64'h0123_4567_89AB_CDEF,
                   64'hAAAA_5555_AAAA_5555, 64'h0123_4567_89AB_CDEF, 0, 1};
        tbl[4] = '{NONE, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                   64'h0, 64'h0, 0, 0};
        d2_valid = 0; d2_op = NONE; d2_mul_v = 0;
        clr_in();
        rst_n = 0;
        #1;
        do_reset();

        // ---- table: issue decode from idle ----
        for (int i = 0; i < 5; i++) begin
            clr_in();
            ivalid = 1; iop = tbl[i].op; r1 = tbl[i].a; r2 = tbl[i].b;
            idest = 6'(i + 10); iptr = 5'(i + 20);
            sample();
            chk("tbl_fpu_a", fa, tbl[i].exp_a);
            chk("tbl_fpu_b", fb, tbl[i].exp_b);
            chk("tbl_add_strobe", addv_o, tbl[i].exp_add);
            chk("tbl_mul_strobe", mulv_o, tbl[i].exp_mul);
            advance();
            idle(2, 100);
        end
        idle(14, 100);

        // ---- FADD end to end with fixed values ----
        clr_in();
        ivalid = 1; iop = FADD; r1 = 64'h3FF0_0000_0000_0000; r2 = 64'h4000_0000_0000_0000;
        idest = 6'd5; iptr = 5'd3;
        sample(); advance();
        clr_in(); add_v = 1; add_res = 64'h4008_0000_0000_0000;
        sample();
        chk("fadd_wb_en", wb_en, 1);
        chk("fadd_wb_data", wb_data, 64'h4008_0000_0000_0000);
        chk("fadd_wb_index", wb_idx, 6'd5);
        chk("fadd_wb_ptr", wb_ptr, 5'd3);
        advance();

        // ---- FADD blocked by FMUL writeback slot ----
        clr_in(); ivalid = 1; iop = FMUL; idest = 6'd7; iptr = 5'd9;
        sample(); advance();
        for (int t = 1; t <= 11; t++) begin clr_in(); sample(); advance(); end
        clr_in(); ivalid = 1; iop = FADD; idest = 6'd8; iptr = 5'd10;
        sample(); chk("slot_conflict_ready_t12", ready, 0); advance();
        clr_in(); ivalid = 1; iop = FADD; idest = 6'd8; iptr = 5'd10;
        mul_v = 1; mul_res = 64'h1234;
        sample();
        chk("slot_free_ready_t13", ready, 1);
        chk("fmul_wb_t13", wb_en, 1);
        chk("fmul_wb_index_t13", wb_idx, 6'd7);
        advance();
        clr_in(); add_v = 1; add_res = 64'h5678;
        sample();
        chk("fadd_wb_t14", wb_en, 1);
        chk("fadd_wb_index_t14", wb_idx, 6'd8);
        advance();

        // ---- flush with three FMULs in flight ----
        for (int t = 0; t < 3; t++) begin
            clr_in(); ivalid = 1; iop = FMUL; idest = 6'(t); iptr = 5'(t);
            sample(); advance();
        end
        idle(2, 100);
        clr_in(); flush = 1; sample(); chk("flush_no_strobe", addv_o | mulv_o, 0); advance();
        for (int t = 6; t <= 16; t++) begin
            clr_in(); mul_v = 1; sample();
            chk("flush_no_wb", wb_en, 0);
            chk("flush_count", cnt, 0);
            advance();
        end

        // ---- reset with three FMULs in flight ----
        for (int t = 0; t < 3; t++) begin
            clr_in(); ivalid = 1; iop = FMUL; idest = 6'(t); iptr = 5'(t);
            sample(); advance();
        end
        idle(2, 100);
        do_reset();
        for (int t = 0; t < 14; t++) begin
            clr_in(); mul_v = 1; add_v = 1; sample();
            chk("rst_late_no_wb", wb_en, 0);
            advance();
        end

        // ---- missing FMUL result ----
        clr_in(); ivalid = 1; iop = FMUL; idest = 6'd2; iptr = 5'd4;
        sample(); advance();
        for (int t = 1; t <= 12; t++) begin clr_in(); sample(); advance(); end
        clr_in(); add_v = 1;
        sample(); chk("drop_no_wb", wb_en, 0); chk("drop_count_before", cnt, 1); advance();
        clr_in(); sample(); chk("drop_error_set", err, 1); chk("drop_count_after", cnt, 0); advance();
        clr_in(); flush = 1; sample(); advance();
        clr_in(); sample(); chk("error_sticky", err, 1); advance();

        // ---- MAX_INFLIGHT=2 instance ----
        do_reset();
        for (int t = 0; t <= 28; t++) begin
            clr_in();
            d2_valid = (t <= 14); d2_op = (t <= 14) ? FMUL : NONE;
            d2_mul_v = (t == 13 || t == 14 || t == 27);
            sample();
            if (t < 2 || t == 14) chk("cap_ready_open", d2_ready, 1);
            if (t >= 2 && t <= 12) chk("cap_ready_stall", d2_ready, 0);
            chk("cap_count_le_max", d2_cnt <= 2, 1);
            if (t == 0) chk("cap_count_t0", d2_cnt, 0);
            if (t >= 2 && t <= 13) chk("cap_count_full", d2_cnt, 2);
            if (t >= 14 && t <= 27) chk("cap_count_one", d2_cnt, 1);
            if (t == 28) chk("cap_count_t28", d2_cnt, 0);
            if (t == 13 || t == 14 || t == 27) chk("cap_wb", d2_wb_en, 1);
            advance();
        end
        d2_valid = 0; d2_op = NONE; d2_mul_v = 0;

        // ---- randomized traffic against the model ----
        for (int c = 0; c < 600; c++) begin
            if (c == 300) do_reset();
            clr_in();
            if (($urandom % 100) < 60) begin
                ivalid = 1;
                iop    = 2'($urandom % 4);
                r1     = {$urandom, $urandom};
                r2     = {$urandom, $urandom};
                idest  = 6'($urandom);
                iptr   = 5'($urandom);
            end
            flush = (($urandom % 100) < 3);
            set_results(93, 6);
            sample();
            advance();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
